// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multicycle core with req/ack instruction and data memory ports
// One FSM pass per instruction: FETCH, DECODE, EXEC, then MEM and/or WB as needed.
module multicycle_core #(
    parameter int WORD_SIZE = 32,
    parameter int IADDR_W   = 8,
    parameter int DADDR_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [IADDR_W-1:0]   imem_addr,
    input  logic [31:0]          imem_rdata,
    input  logic                 imem_ack,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [DADDR_W-1:0]   dmem_addr,
    output logic [WORD_SIZE-1:0] dmem_wdata,
    input  logic [WORD_SIZE-1:0] dmem_rdata,
    input  logic                 dmem_ack,
    output logic [WORD_SIZE-1:0] output_data,
    output logic [3:0]           flags,
    output logic [IADDR_W-1:0]   pc_out,
    output logic                 halted,
    output logic                 illegal
);

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_ORR  = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_LDR  = 5'd6;
    localparam logic [4:0] OP_STR  = 5'd7;
    localparam logic [4:0] OP_B    = 5'd8;
    localparam logic [4:0] OP_BEQ  = 5'd9;
    localparam logic [4:0] OP_HALT = 5'd10;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [IADDR_W-1:0]    r_pc;
    logic [31:0]           r_ir;
    logic [WORD_SIZE-1:0]  r_a;
    logic [WORD_SIZE-1:0]  r_b;
    logic [WORD_SIZE-1:0]  r_d;
    logic [WORD_SIZE-1:0]  r_result;
    logic [DADDR_W-1:0]    r_addr;
    logic [3:0]            r_flags;
    logic [WORD_SIZE-1:0]  r_out;
    logic                  r_illegal;
    logic [WORD_SIZE-1:0]  r_rf [16];

    logic [4:0]            w_op;
    logic [3:0]            w_rd;
    logic [3:0]            w_rn;
    logic [3:0]            w_rm;
    logic [WORD_SIZE-1:0]  w_imm;
    logic                  w_is_alu;
    logic                  w_is_bad;
    logic [WORD_SIZE-1:0]  w_opb;
    logic                  w_cin;
    logic [WORD_SIZE:0]    w_sum;
    logic [WORD_SIZE-1:0]  w_res;
    logic [3:0]            w_flags;
    logic [IADDR_W-1:0]    w_pc_inc;
    logic [IADDR_W-1:0]    w_pc_br;

    assign w_op     = r_ir[31:27];
    assign w_rd     = r_ir[26:23];
    assign w_rn     = r_ir[22:19];
    assign w_rm     = r_ir[18:15];
    assign w_imm    = {{(WORD_SIZE-15){r_ir[14]}}, r_ir[14:0]};
    assign w_is_alu = (w_op >= OP_ADD) && (w_op <= OP_ADDI);
    assign w_is_bad = (w_op > OP_HALT);
    assign w_pc_inc = r_pc + IADDR_W'(1);
    assign w_pc_br  = w_pc_inc + w_imm[IADDR_W-1:0];

    // One adder serves ADD/SUB/ADDI and the LDR/STR effective address.
    always_comb begin
        w_opb = w_imm;
        w_cin = 1'b0;
        if (w_op == OP_ADD) begin
            w_opb = r_b;
        end else if (w_op == OP_SUB) begin
            w_opb = ~r_b;
            w_cin = 1'b1;
        end
        w_sum = {1'b0, r_a} + {1'b0, w_opb} + (WORD_SIZE+1)'(w_cin);
        case (w_op)
            OP_AND:  w_res = r_a & r_b;
            OP_ORR:  w_res = r_a | r_b;
            default: w_res = w_sum[WORD_SIZE-1:0];
        endcase
        w_flags[3] = w_res[WORD_SIZE-1];
        w_flags[2] = (w_res == '0);
        w_flags[1] = r_flags[1];
        w_flags[0] = r_flags[0];
        if ((w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_ADDI)) begin
            w_flags[1] = w_sum[WORD_SIZE];
            w_flags[0] = (r_a[WORD_SIZE-1] == w_opb[WORD_SIZE-1]) &&
                         (w_sum[WORD_SIZE-1] != r_a[WORD_SIZE-1]);
        end
    end

    always_comb begin
        w_next     = r_state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        imem_addr  = r_pc;
        dmem_addr  = r_addr;
        dmem_wdata = r_d;
        case (r_state)
            S_FETCH: begin
                // Held low while in reset so no fetch is presented during it.
                imem_req = rst;
                if (imem_ack) w_next = S_DECODE;
            end
            S_DECODE: begin
                if ((w_op == OP_HALT) || w_is_bad) w_next = S_HALT;
                else                               w_next = S_EXEC;
            end
            S_EXEC: begin
                if (w_is_alu)                                w_next = S_WB;
                else if ((w_op == OP_LDR) || (w_op == OP_STR)) w_next = S_MEM;
                else                                         w_next = S_FETCH;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (w_op == OP_STR);
                if (dmem_ack) w_next = (w_op == OP_LDR) ? S_WB : S_FETCH;
            end
            S_WB:    w_next = S_FETCH;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_d       <= '0;
            r_result  <= '0;
            r_addr    <= '0;
            r_flags   <= '0;
            r_out     <= '0;
            r_illegal <= 1'b0;
            for (int i = 0; i < 16; i++) r_rf[i] <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) r_ir <= imem_rdata;
                end
                S_DECODE: begin
                    r_a <= r_rf[w_rn];
                    r_b <= r_rf[w_rm];
                    r_d <= r_rf[w_rd];
                    if (w_is_bad) r_illegal <= 1'b1;
                end
                S_EXEC: begin
                    r_result <= w_res;
                    r_addr   <= w_sum[DADDR_W-1:0];
                    if (w_is_alu) r_flags <= w_flags;
                    if (w_op == OP_B)        r_pc <= w_pc_br;
                    else if (w_op == OP_BEQ) r_pc <= r_flags[2] ? w_pc_br : w_pc_inc;
                    else if (w_op == OP_NOP) r_pc <= w_pc_inc;
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (w_op == OP_LDR) r_result <= dmem_rdata;
                        else                r_pc     <= w_pc_inc;
                    end
                end
                S_WB: begin
                    // R0 is never written, so it keeps its reset value of zero.
                    if (w_rd != 4'd0) r_rf[w_rd] <= r_result;
                    r_out <= r_result;
                    r_pc  <= w_pc_inc;
                end
                default: ;
            endcase
        end
    end

    assign output_data = r_out;
    assign flags       = r_flags;
    assign pc_out      = r_pc;
    assign halted      = (r_state == S_HALT);
    assign illegal     = r_illegal;

endmodule
